padlock_multi: RTL and testbench

Parametrised combination padlock: accepts digit presses from an N-key keypad, compares the last CODE_LEN digits against a run-time programmable code on an `open` strobe, and drives `lock` low for a bounded unlock window. Adds a saturating entry buffer, an auto-relock timer, code reprogramming while unlocked, and an optional brute-force lockout. It replaces the fixed 4-digit padlock at the same position between the debounced button inputs and the lock actuator.

---
 rtl/padlock_pkg.sv | 18 +
 rtl/padlock_multi_if.sv | 30 +++
 rtl/padlock_keyenc.sv | 21 ++
 rtl/padlock_multi.sv | 156 +++++++++++++++
 tb/tb_padlock_multi.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/padlock_pkg.sv
// Shared types and helpers for the multi-digit padlock.
package padlock_pkg;

  typedef enum logic [1:0] {
    StLocked,
    StOpen,
    StLockout
  } state_e;

  // Bits needed to encode one keypad digit; never narrower than one bit.
  function automatic int unsigned digit_w(int unsigned n_keys);
    return (n_keys > 2) ? $clog2(n_keys) : 1;
  endfunction

  // Code 2,1,3,0 in entry order for the default 4-key, 4-digit geometry.
  localparam logic [7:0] DefaultResetCode = 8'h36;

endpackage

// File: rtl/padlock_multi_if.sv
// Keypad/actuator bundle between the debounced buttons and the padlock core.
interface padlock_multi_if #(
  parameter int unsigned N_KEYS   = 4,
  parameter int unsigned CODE_LEN = 4
);
  import padlock_pkg::*;

  localparam int unsigned KW = digit_w(N_KEYS);
  localparam int unsigned DW = $clog2(CODE_LEN + 1);

  logic [N_KEYS-1:0]      keys;
  logic                   open;
  logic                   relock;
  logic                   code_wr;
  logic [CODE_LEN*KW-1:0] code_in;
  logic                   lock;
  logic                   locked_out;
  logic [DW-1:0]          digits;

  modport master (
    output keys, open, relock, code_wr, code_in,
    input  lock, locked_out, digits
  );

  modport slave (
    input  keys, open, relock, code_wr, code_in,
    output lock, locked_out, digits
  );

endinterface

// File: rtl/padlock_keyenc.sv
// Keypad strobe encoder: lowest asserted key index wins.
module padlock_keyenc
  import padlock_pkg::*;
#(
  parameter int unsigned N_KEYS = 4
) (
  input  logic [N_KEYS-1:0]            keys,
  output logic                         valid,
  output logic [digit_w(N_KEYS)-1:0]   digit
);
  localparam int unsigned KW = digit_w(N_KEYS);

  always_comb begin
    valid = |keys;
    digit = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) digit = KW'(i);
    end
  end

endmodule

// File: rtl/padlock_multi.sv
// Programmable combination padlock with auto-relock timer.
// Optional brute-force lockout is built when PADLOCK_LOCKOUT_EN is defined.
module padlock_multi
  import padlock_pkg::*;
#(
  parameter int unsigned N_KEYS                              = 4,
  parameter int unsigned CODE_LEN                            = 4,
  parameter logic [CODE_LEN*digit_w(N_KEYS)-1:0] RESET_CODE  = DefaultResetCode,
  parameter int unsigned UNLOCK_CYCLES                       = 256,
  parameter int unsigned MAX_FAILS                           = 3,
  parameter int unsigned LOCKOUT_CYCLES                      = 1024
) (
  input logic            clk,
  input logic            reset,
  padlock_multi_if.slave bus
);
  localparam int unsigned KW = digit_w(N_KEYS);
  localparam int unsigned DW = $clog2(CODE_LEN + 1);
  localparam int unsigned BW = CODE_LEN * KW;
`ifdef PADLOCK_LOCKOUT_EN
  localparam int unsigned TMax = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                  : LOCKOUT_CYCLES;
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
`else
  localparam int unsigned TMax = UNLOCK_CYCLES;
`endif
  localparam int unsigned TW = (TMax > 1) ? $clog2(TMax) : 1;

  if (N_KEYS < 2 || CODE_LEN < 1 || UNLOCK_CYCLES < 1 || MAX_FAILS < 1 ||
      LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("padlock_multi: illegal parameter value");
  end

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            key_valid;
  logic [KW-1:0]   key_digit;
  logic            match;

  padlock_keyenc #(
    .N_KEYS(N_KEYS)
  ) u_keyenc (
    .keys  (bus.keys),
    .valid (key_valid),
    .digit (key_digit)
  );

  assign match = (cnt_q == DW'(CODE_LEN)) && (buf_q == code_q);

`ifdef PADLOCK_LOCKOUT_EN
  logic [FW-1:0] fails_q, fails_d;
  logic          last_try;

  assign last_try = (fails_q == FW'(MAX_FAILS - 1));

  always_comb begin
    fails_d = fails_q;
    if (state_q == StLocked && bus.open) begin
      fails_d = match ? '0 : fails_q + FW'(1);
    end else if (state_q == StLockout && state_d == StLocked) begin
      fails_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fails_q <= '0;
    else       fails_q <= fails_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= StLocked;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLocked: begin
        if (bus.open && match) begin
          state_d = StOpen;
`ifdef PADLOCK_LOCKOUT_EN
        end else if (bus.open && last_try) begin
          state_d = StLockout;
`endif
        end
      end
      StOpen: begin
        if (bus.relock || timer_q == '0) state_d = StLocked;
      end
`ifdef PADLOCK_LOCKOUT_EN
      StLockout: begin
        if (timer_q == '0) state_d = StLocked;
      end
`endif
      default: state_d = StLocked;
    endcase
  end

  always_comb begin
    bus.lock   = (state_q != StOpen);
    bus.digits = cnt_q;
`ifdef PADLOCK_LOCKOUT_EN
    bus.locked_out = (state_q == StLockout);
`else
    bus.locked_out = 1'b0;
`endif
  end

  // Entry buffer, stored code and the shared unlock/lockout countdown.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    unique case (state_q)
      StLocked: begin
        // A check consumes the buffer; a key in the same cycle is dropped.
        if (bus.open) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (key_valid) begin
          buf_d = buf_q >> KW;
          buf_d[BW-1 -: KW] = key_digit;
          if (cnt_q != DW'(CODE_LEN)) cnt_d = cnt_q + DW'(1);
        end
        if (state_d == StOpen) timer_d = TW'(UNLOCK_CYCLES - 1);
`ifdef PADLOCK_LOCKOUT_EN
        if (state_d == StLockout) timer_d = TW'(LOCKOUT_CYCLES - 1);
`endif
      end
      StOpen: begin
        if (bus.code_wr) code_d = bus.code_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      code_q  <= RESET_CODE;
      timer_q <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_padlock_multi.sv
// Self-checking bench for padlock_multi: vector table, corner sequences, random vs. model.
module tb_padlock_multi;
  localparam int unsigned NK = 4;
  localparam int unsigned CL = 4;
  localparam int unsigned KW = 2;
  localparam int unsigned UC = 256;
  localparam int unsigned LC = 1024;
  localparam int unsigned MF = 3;
  localparam logic [CL*KW-1:0] RCODE = 8'h36;  // 2,1,3,0 in entry order

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  padlock_multi_if #(.N_KEYS(NK), .CODE_LEN(CL)) bus ();

  padlock_multi #(
    .N_KEYS         (NK),
    .CODE_LEN       (CL),
    .RESET_CODE     (RCODE),
    .UNLOCK_CYCLES  (UC),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: mode 0 locked, 1 open, 2 lockout.
  int m_mode  = 0;
  int m_left  = 0;
  int m_fails = 0;
  int m_hist[$];
  int m_code[CL];

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][1:0] d;
    logic [2:0]      exp_digits;
    logic            opens;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(int n, int a, int b, int c, int d, int e, int f, int ed,
                              bit op);
    vec_t v;
    v.n = 3'(n);
    v.d[0] = 2'(a); v.d[1] = 2'(b); v.d[2] = 2'(c);
    v.d[3] = 2'(d); v.d[4] = 2'(e); v.d[5] = 2'(f);
    v.exp_digits = 3'(ed);
    v.opens = op;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_step(logic [NK-1:0] k, bit op, bit rl, bit wr,
                                     logic [CL*KW-1:0] ci);
    bit ok;
    int low;
    if (reset) begin
      m_mode = 0; m_left = 0; m_fails = 0;
      m_hist.delete();
      for (int i = 0; i < CL; i++) m_code[i] = int'(RCODE[i*KW +: KW]);
      return;
    end
    case (m_mode)
      0: begin
        if (op) begin
          ok = (m_hist.size() == CL);
          for (int i = 0; i < m_hist.size(); i++) if (m_hist[i] != m_code[i]) ok = 0;
          m_hist.delete();
          if (ok) begin
            m_mode = 1; m_left = UC; m_fails = 0;
          end else begin
`ifdef PADLOCK_LOCKOUT_EN
            m_fails++;
            if (m_fails == MF) begin
              m_mode = 2; m_left = LC;
            end
`endif
          end
        end else if (k != '0) begin
          low = -1;
          for (int i = NK - 1; i >= 0; i--) if (k[i]) low = i;
          m_hist.push_back(low);
          if (m_hist.size() > CL) void'(m_hist.pop_front());
        end
      end
      1: begin
        if (wr) for (int i = 0; i < CL; i++) m_code[i] = int'(ci[i*KW +: KW]);
        m_left--;
        if (m_left == 0 || rl) m_mode = 0;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_fails = 0;
        end
      end
    endcase
  endfunction

  function automatic int model_out();
    return ((m_mode != 1) ? 16 : 0) + ((m_mode == 2) ? 8 : 0) + m_hist.size();
  endfunction

  task automatic tick(input logic [NK-1:0] k, input bit op = 1'b0, input bit rl = 1'b0,
                      input bit wr = 1'b0, input logic [CL*KW-1:0] ci = '0);
    bus.keys = k; bus.open = op; bus.relock = rl; bus.code_wr = wr; bus.code_in = ci;
    @(posedge clk);
    model_step(k, op, rl, wr, ci);
    #1;
    check("outputs{lock,locked_out,digits}",
          int'({bus.lock, bus.locked_out, bus.digits}), model_out());
    bus.keys = '0; bus.open = 1'b0; bus.relock = 1'b0; bus.code_wr = 1'b0;
  endtask

  task automatic press(input int d);
    logic [NK-1:0] k;
    k = '0;
    k[d] = 1'b1;
    tick(k);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic rand_tick();
    logic [NK-1:0] k;
    k = ($urandom_range(0, 2) == 0) ? NK'($urandom_range(1, 15)) : '0;
    tick(k, $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
         $urandom_range(0, 29) == 0, (CL*KW)'($urandom()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int low;
    int lo_cnt;
    bus.keys = '0; bus.open = 1'b0; bus.relock = 1'b0; bus.code_wr = 1'b0;
    bus.code_in = '0;

    vecs[0]  = mk(4, 2, 1, 3, 0, 0, 0, 4, 1'b1);
    vecs[1]  = mk(5, 0, 2, 1, 3, 0, 0, 4, 1'b1);
    vecs[2]  = mk(3, 2, 1, 3, 0, 0, 0, 3, 1'b0);
    vecs[3]  = mk(4, 0, 1, 3, 2, 0, 0, 4, 1'b0);
    vecs[4]  = mk(6, 3, 3, 2, 1, 3, 0, 4, 1'b1);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1'b0);
    vecs[6]  = mk(2, 2, 1, 0, 0, 0, 0, 2, 1'b0);
    vecs[7]  = mk(4, 2, 1, 3, 0, 0, 0, 4, 1'b1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[9]  = mk(4, 2, 1, 3, 1, 0, 0, 4, 1'b0);
    vecs[10] = mk(4, 2, 1, 3, 0, 0, 0, 4, 1'b1);

    // Reset state and exact unlock window.
    reset = 1'b1;
    tick('0);
    reset = 1'b0;
    check("reset lock", int'(bus.lock), 1);
    check("reset locked_out", int'(bus.locked_out), 0);
    check("reset digits", int'(bus.digits), 0);
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    low = (bus.lock == 1'b0) ? 1 : 0;
    for (int j = 0; j < 300 && bus.lock == 1'b0; j++) begin
      tick('0);
      if (bus.lock == 1'b0) low++;
    end
    check("unlock window length", low, UC);

    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++) press(int'(vecs[i].d[j]));
      check($sformatf("vec%0d digits", i), int'(bus.digits), int'(vecs[i].exp_digits));
      tick('0, 1'b1);
      check($sformatf("vec%0d lock", i), int'(bus.lock), vecs[i].opens ? 0 : 1);
      check($sformatf("vec%0d digits cleared", i), int'(bus.digits), 0);
      if (vecs[i].opens) begin
        tick('0, 1'b0, 1'b1);
        check($sformatf("vec%0d relock", i), int'(bus.lock), 1);
      end
    end

    // Open coincident with the final key; relock five cycles into OPEN.
    press(2); press(1); press(3);
    tick(4'b0001, 1'b1);
    check("open with final key fails", int'(bus.lock), 1);
    check("open with final key digits", int'(bus.digits), 0);
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    repeat (5) tick('0);
    check("open after 5 cycles", int'(bus.lock), 0);
    tick('0, 1'b0, 1'b1);
    check("relock next cycle", int'(bus.lock), 1);

    // Reprogram to 1,1,1,1.
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    tick('0, 1'b0, 1'b0, 1'b1, 8'h55);
    tick('0, 1'b0, 1'b1);
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    check("old code rejected", int'(bus.lock), 1);
    enter4(1, 1, 1, 1);
    tick('0, 1'b1);
    check("new code accepted", int'(bus.lock), 0);
    tick('0, 1'b0, 1'b0, 1'b1, 8'hFF);

    // Reset while open after reprogramming.
    reset = 1'b1;
    tick('0);
    reset = 1'b0;
    check("reset in open lock", int'(bus.lock), 1);
    check("reset in open digits", int'(bus.digits), 0);
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    check("reset code restored", int'(bus.lock), 0);
    tick('0, 1'b0, 1'b1);

    // Three consecutive wrong codes.
    for (int r = 0; r < 3; r++) begin
      enter4(3, 3, 3, 3);
      tick('0, 1'b1);
    end
`ifdef PADLOCK_LOCKOUT_EN
    check("lockout entry", int'(bus.locked_out), 1);
    lo_cnt = 1;
    for (int j = 0; j < 1100 && bus.locked_out == 1'b1; j++) begin
      if (j < 4) press(m_code[j]);
      else if (j == 4) tick('0, 1'b1);
      else tick('0);
      if (j == 4) check("open ignored in lockout", int'(bus.lock), 1);
      if (bus.locked_out == 1'b1) lo_cnt++;
    end
    check("lockout length", lo_cnt, LC);
    enter4(2, 1, 3, 0);
    tick('0, 1'b1);
    check("unlock after lockout", int'(bus.lock), 0);
    tick('0, 1'b0, 1'b1);
`else
    check("no lockout in default build", int'(bus.locked_out), 0);
    lo_cnt = 0;
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 20)) rand_tick();
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < CL; j++) press(m_code[j]);
      end else begin
        for (int j = 0; j < CL; j++) press(int'($urandom_range(0, 3)));
      end
      tick('0, 1'b1);
      repeat ($urandom_range(0, 300)) rand_tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
